// File: rtl/rdoq_rate_pkg.sv
// Shared types for the CG rate sequencer: level classes, FSM states, c1Idx saturation
// and the level-to-class mapping.
package rdoq_rate_pkg;

    typedef enum logic [1:0] {
        ZERO     = 2'd0,
        ONE      = 2'd1,
        TWO      = 2'd2,
        BASEPLUS = 2'd3
    } level_case_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        EMIT  = 2'd3
    } cgrs_state_e;

    localparam int unsigned C1_SAT = 8;

    // Callers zero-extend their level to 32 bits before classifying it.
    function automatic level_case_e level_to_case(input logic [31:0] level);
        if (level >= 32'd3) begin
            return BASEPLUS;
        end
        return level_case_e'(level[1:0]);
    endfunction

endpackage

// File: rtl/cg_rate_sequencer_if.sv
// Bus bundle of the CG rate sequencer: level beats in, lookup request/response, CG total out.
// The master modport is the sequencer; the slave modport is its environment.
interface cg_rate_sequencer_if #(
    parameter int LEVEL_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [LEVEL_W-1:0] in_level;
    logic [15:0]        in_g1_cost;
    logic [15:0]        in_abs_cost;
    logic               in_last;
    logic               flush;

    logic               lk_start;
    logic [1:0]         lk_level_case;
    logic [7:0]         lk_c1Idx;
    logic [7:0]         lk_c2Idx;
    logic [15:0]        lk_g1_cost;
    logic [15:0]        lk_abs_cost;
    logic               lk_done;
    logic [31:0]        lk_bits;

    logic               cg_valid;
    logic               cg_ready;
    logic [31:0]        cg_bits;
    logic [4:0]         cg_count;
    logic               err_timeout;

    modport master (
        input  in_valid, in_level, in_g1_cost, in_abs_cost, in_last, flush,
        input  lk_done, lk_bits, cg_ready,
        output in_ready, lk_start, lk_level_case, lk_c1Idx, lk_c2Idx,
        output lk_g1_cost, lk_abs_cost, cg_valid, cg_bits, cg_count, err_timeout
    );

    modport slave (
        output in_valid, in_level, in_g1_cost, in_abs_cost, in_last, flush,
        output lk_done, lk_bits, cg_ready,
        input  in_ready, lk_start, lk_level_case, lk_c1Idx, lk_c2Idx,
        input  lk_g1_cost, lk_abs_cost, cg_valid, cg_bits, cg_count, err_timeout
    );

endinterface

// File: rtl/cgrs_ctx_tracker.sv
// c1Idx / c2Idx context counters for one coefficient group.
// c2Idx only advances for level>=2 coefficients seen while c1Idx is still below C1_SAT.
module cgrs_ctx_tracker
    import rdoq_rate_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       inc,
    input  logic       ge2,
    output logic [7:0] c1_idx,
    output logic [7:0] c2_idx
);

    logic c1_below_sat;

    assign c1_below_sat = (c1_idx < 8'(C1_SAT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c1_idx <= '0;
            c2_idx <= '0;
        end else if (clear) begin
            c1_idx <= '0;
            c2_idx <= '0;
        end else if (inc) begin
            if (c1_below_sat) begin
                c1_idx <= c1_idx + 8'd1;
            end
            if (ge2 && c1_below_sat && (c2_idx != 8'hFF)) begin
                c2_idx <= c2_idx + 8'd1;
            end
        end
    end

endmodule

// File: rtl/cg_rate_sequencer.sv
// Walks one coefficient group, issues a context-bit lookup per nonzero level and emits the
// saturated CG rate total. Define CGRS_TIMEOUT_EN to bound the wait for lk_done.
module cg_rate_sequencer
    import rdoq_rate_pkg::*;
#(
    parameter int CG_SIZE = 16,
    parameter int LEVEL_W = 16,
    parameter int TIMEOUT = 64
) (
    input logic                 clk,
    input logic                 rst_n,
    cg_rate_sequencer_if.master bus
);

    if (CG_SIZE < 1 || CG_SIZE > 31 || LEVEL_W < 2 || LEVEL_W > 32 || TIMEOUT < 1) begin : g_param_check
        $error("cg_rate_sequencer: unsupported CG_SIZE/LEVEL_W/TIMEOUT");
    end

    cgrs_state_e state, state_nxt;
    level_case_e beat_case, case_q;
    logic [15:0] g1_q, abs_q;
    logic        last_q;
    logic [31:0] acc;
    logic [4:0]  count;
    logic        beat_acc, beat_last, lk_fire, cg_take;
    logic [31:0] lk_add;
    logic [32:0] acc_sum;
    logic [7:0]  c1_idx, c2_idx;

    assign beat_case = level_to_case(32'(bus.in_level));
    assign beat_acc  = (state == IDLE) && bus.in_valid && !bus.flush;
    // The CG_SIZE-th beat closes the group even without in_last.
    assign beat_last = bus.in_last || (count == 5'(CG_SIZE - 1));
    assign cg_take   = (state == EMIT) && bus.cg_ready && !bus.flush;
    assign acc_sum   = {1'b0, acc} + {1'b0, lk_add};

`ifdef CGRS_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] wait_cycles;
    logic             tmo;
    logic             err_q;

    // Fires on the TIMEOUT-th WAIT cycle without lk_done; the lookup is then treated as 0 bits.
    assign tmo     = (state == WAIT) && !bus.lk_done && (wait_cycles == TMR_W'(TIMEOUT - 1));
    assign lk_fire = (state == WAIT) && (bus.lk_done || tmo) && !bus.flush;
    assign lk_add  = bus.lk_done ? bus.lk_bits : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cycles <= '0;
            err_q       <= 1'b0;
        end else begin
            if ((state != WAIT) || bus.lk_done || bus.flush) begin
                wait_cycles <= '0;
            end else begin
                wait_cycles <= wait_cycles + TMR_W'(1);
            end
            if (tmo && !bus.flush) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.err_timeout = err_q;
`else
    assign lk_fire         = (state == WAIT) && bus.lk_done && !bus.flush;
    assign lk_add          = bus.lk_bits;
    assign bus.err_timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default-first assignment keeps combinational blocks free of inferred latches.
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (beat_acc) begin
                        if (beat_case == ZERO) begin
                            state_nxt = beat_last ? EMIT : IDLE;
                        end else begin
                            state_nxt = ISSUE;
                        end
                    end
                end
                ISSUE:   state_nxt = WAIT;
                WAIT:    if (lk_fire) state_nxt = last_q ? EMIT : IDLE;
                EMIT:    if (bus.cg_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.in_ready = 1'b0;
        bus.lk_start = 1'b0;
        bus.cg_valid = 1'b0;
        case (state)
            IDLE:    bus.in_ready = 1'b1;
            ISSUE:   bus.lk_start = 1'b1;
            EMIT:    bus.cg_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            case_q <= ZERO;
            g1_q   <= '0;
            abs_q  <= '0;
            last_q <= 1'b0;
        end else if (beat_acc) begin
            case_q <= beat_case;
            g1_q   <= bus.in_g1_cost;
            abs_q  <= bus.in_abs_cost;
            last_q <= beat_last;
        end
    end

    // Flush and the downstream handshake both return the group state to empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
        end else if (bus.flush || cg_take) begin
            acc   <= '0;
            count <= '0;
        end else if (beat_acc && (beat_case == ZERO)) begin
            count <= count + 5'd1;
        end else if (lk_fire) begin
            acc   <= acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0];
            count <= count + 5'd1;
        end
    end

    cgrs_ctx_tracker u_ctx_tracker (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (bus.flush || cg_take),
        .inc    (lk_fire),
        .ge2    ((case_q == TWO) || (case_q == BASEPLUS)),
        .c1_idx (c1_idx),
        .c2_idx (c2_idx)
    );

    assign bus.lk_level_case = case_q;
    assign bus.lk_c1Idx      = c1_idx;
    assign bus.lk_c2Idx      = c2_idx;
    assign bus.lk_g1_cost    = g1_q;
    assign bus.lk_abs_cost   = abs_q;
    assign bus.cg_bits       = acc;
    assign bus.cg_count      = count;

endmodule

// File: tb/tb_cg_rate_sequencer.sv
// Self-checking bench for cg_rate_sequencer: a behavioural lookup engine plus a per-CG
// reference model computed from the level list.
module tb_cg_rate_sequencer;
    import rdoq_rate_pkg::*;

    localparam int CG_SIZE = 16;
    localparam int LEVEL_W = 16;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cg_rate_sequencer_if #(.LEVEL_W(LEVEL_W)) bus ();

    cg_rate_sequencer #(
        .CG_SIZE (CG_SIZE),
        .LEVEL_W (LEVEL_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  lc;
        logic [7:0]  c1;
        logic [7:0]  c2;
        logic [15:0] g1;
        logic [15:0] ab;
    } req_t;

    int          tests_run = 0;
    int          tests_failed = 0;
    req_t        req_log[$];
    int          req_rd = 0;
    bit          resp_en = 1'b1;
    bit          fixed_en = 1'b0;
    logic [31:0] fixed_bits = 32'd0;

    logic [15:0] cg_lvl[CG_SIZE];
    logic [15:0] cg_g1[CG_SIZE];
    logic [15:0] cg_ab[CG_SIZE];
    bit          cg_last[CG_SIZE];

    // Lookup engine: ONE costs greaterOne only, TWO and above add the levelAbs cost.
    function automatic logic [31:0] coef_bits(input logic [15:0] lvl, input logic [15:0] g1,
                                               input logic [15:0] ab);
        if (fixed_en) return fixed_bits;
        if (lvl == 16'd1) return 32'(g1);
        return 32'(g1) + 32'(ab);
    endfunction

    initial begin : lookup_engine
        bit          pending;
        logic [31:0] bits_q;
        pending = 1'b0;
        bits_q  = '0;
        bus.lk_done = 1'b0;
        bus.lk_bits = '0;
        forever begin
            @(negedge clk);
            bus.lk_done = 1'b0;
            if (pending && resp_en) begin
                bus.lk_done = 1'b1;
                bus.lk_bits = bits_q;
            end
            pending = 1'b0;
            if (bus.lk_start === 1'b1) begin
                req_log.push_back('{bus.lk_level_case, bus.lk_c1Idx, bus.lk_c2Idx,
                                    bus.lk_g1_cost, bus.lk_abs_cost});
                bits_q  = coef_bits(16'(bus.lk_level_case), bus.lk_g1_cost, bus.lk_abs_cost);
                pending = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [15:0] lvl, input logic last, input logic [15:0] g1,
                             input logic [15:0] ab);
        int k = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL beat_ready: in_ready=%b required 1 within 200 cycles", bus.in_ready);
            return;
        end
        bus.in_valid    = 1'b1;
        bus.in_level    = lvl;
        bus.in_last     = last;
        bus.in_g1_cost  = g1;
        bus.in_abs_cost = ab;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (lvl != 16'd0) begin
            tests_run++;
            if (bus.lk_start !== 1'b1 || bus.in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL issue_latency: lk_start=%b in_ready=%b required 1/0",
                         bus.lk_start, bus.in_ready);
            end
        end
    endtask

    // Sends the beats in cg_* up to in_last or the CG_SIZE-th beat, checks the total and requests.
    task automatic run_cg(input string name, input int hold);
        int          n;
        int          nz;
        int          early_ge2;
        int          k;
        logic [32:0] sum;
        logic [31:0] exp_bits;
        req_t        exp_q[$];
        n = 0;
        for (int i = 0; i < CG_SIZE; i++) begin
            n++;
            if (cg_last[i]) break;
        end
        exp_bits  = '0;
        nz        = 0;
        early_ge2 = 0;
        for (int i = 0; i < n; i++) begin
            if (cg_lvl[i] != 16'd0) begin
                exp_q.push_back('{(cg_lvl[i] >= 16'd3) ? 2'd3 : cg_lvl[i][1:0],
                                  8'((nz < 8) ? nz : 8),
                                  8'((early_ge2 < 255) ? early_ge2 : 255),
                                  cg_g1[i], cg_ab[i]});
                if (cg_lvl[i] >= 16'd2 && nz < 8) early_ge2++;
                nz++;
                sum      = {1'b0, exp_bits} + {1'b0, coef_bits(cg_lvl[i], cg_g1[i], cg_ab[i])};
                exp_bits = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
            end
        end
        for (int i = 0; i < n; i++) begin
            send_beat(cg_lvl[i], cg_last[i], cg_g1[i], cg_ab[i]);
        end
        k = 0;
        while (bus.cg_valid !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        tests_run++;
        if (bus.cg_valid !== 1'b1 || bus.cg_bits !== exp_bits || bus.cg_count !== 5'(n)) begin
            tests_failed++;
            $display("FAIL %s total: valid=%b bits=%h count=%0d required 1/%h/%0d",
                     name, bus.cg_valid, bus.cg_bits, bus.cg_count, exp_bits, n);
        end
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.in_level = 16'd0;
            bus.in_last  = 1'b1;
            @(negedge clk);
            tests_run++;
            if (bus.cg_valid !== 1'b1 || bus.cg_bits !== exp_bits || bus.in_ready !== 1'b0 ||
                bus.lk_start !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s hold: valid=%b bits=%h in_ready=%b lk_start=%b required 1/%h/0/0",
                         name, bus.cg_valid, bus.cg_bits, bus.in_ready, bus.lk_start, exp_bits);
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.cg_ready = 1'b1;
        @(negedge clk);
        bus.cg_ready = 1'b0;
        tests_run++;
        if (bus.cg_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s release: valid=%b in_ready=%b required 0/1",
                     name, bus.cg_valid, bus.in_ready);
        end
        tests_run++;
        if (req_log.size() - req_rd != exp_q.size()) begin
            tests_failed++;
            $display("FAIL %s req_count: got %0d required %0d",
                     name, req_log.size() - req_rd, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && req_rd + i < req_log.size(); i++) begin
            tests_run++;
            if (req_log[req_rd+i] != exp_q[i]) begin
                tests_failed++;
                $display("FAIL %s req%0d: case=%0d c1=%0d c2=%0d g1=%0d abs=%0d required %0d/%0d/%0d/%0d/%0d",
                         name, i, req_log[req_rd+i].lc, req_log[req_rd+i].c1, req_log[req_rd+i].c2,
                         req_log[req_rd+i].g1, req_log[req_rd+i].ab, exp_q[i].lc, exp_q[i].c1,
                         exp_q[i].c2, exp_q[i].g1, exp_q[i].ab);
            end
        end
        req_rd = req_log.size();
    endtask

    task automatic clear_cg();
        for (int i = 0; i < CG_SIZE; i++) begin
            cg_lvl[i]  = 16'd0;
            cg_g1[i]   = 16'd10;
            cg_ab[i]   = 16'd5;
            cg_last[i] = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.lk_start !== 1'b0 || bus.cg_valid !== 1'b0 ||
            bus.cg_bits !== 32'd0 || bus.cg_count !== 5'd0 || bus.err_timeout !== 1'b0 ||
            bus.lk_c1Idx !== 8'd0 || bus.lk_c2Idx !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_state: rdy=%b start=%b valid=%b bits=%h cnt=%0d err=%b c1=%0d c2=%0d required 1/0/0/0/0/0/0/0",
                     bus.in_ready, bus.lk_start, bus.cg_valid, bus.cg_bits, bus.cg_count,
                     bus.err_timeout, bus.lk_c1Idx, bus.lk_c2Idx);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.cg_valid !== 1'b0 || bus.cg_count !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_release: rdy=%b valid=%b cnt=%0d required 1/0/0",
                     bus.in_ready, bus.cg_valid, bus.cg_count);
        end
    endtask

    task automatic test_basic();
        clear_cg();
        cg_lvl[0] = 16'd1;
        cg_lvl[1] = 16'd2;
        cg_lvl[2] = 16'd3;
        cg_lvl[3] = 16'd0;
        cg_last[3] = 1'b1;
        run_cg("basic", 0);
    endtask

    task automatic test_implicit_last();
        clear_cg();
        for (int i = 0; i < CG_SIZE; i++) cg_lvl[i] = 16'd1;
        run_cg("implicit_last", 1);
    endtask

    task automatic test_saturation();
        clear_cg();
        fixed_en   = 1'b1;
        fixed_bits = 32'hFFFF_FFF0;
        cg_lvl[0]  = 16'd1;
        cg_lvl[1]  = 16'd1;
        cg_last[1] = 1'b1;
        run_cg("saturate", 0);
        fixed_en = 1'b0;
    endtask

    task automatic test_backpressure();
        clear_cg();
        cg_lvl[0]  = 16'd2;
        cg_last[0] = 1'b1;
        run_cg("backpressure", 5);
        clear_cg();
        cg_lvl[0]  = 16'd0;
        cg_lvl[1]  = 16'd4;
        cg_last[1] = 1'b1;
        run_cg("after_backpressure", 0);
    endtask

    task automatic test_flush();
        send_beat(16'd0, 1'b0, 16'd10, 16'd5);
        send_beat(16'd2, 1'b0, 16'd10, 16'd5);
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.cg_valid !== 1'b0 || bus.lk_c1Idx !== 8'd0) begin
            tests_failed++;
            $display("FAIL flush_wait: rdy=%b valid=%b c1=%0d required 1/0/0",
                     bus.in_ready, bus.cg_valid, bus.lk_c1Idx);
        end
        req_rd = req_log.size();
        bus.in_valid = 1'b1;
        bus.in_level = 16'd0;
        bus.in_last  = 1'b1;
        bus.flush    = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.flush    = 1'b0;
        @(negedge clk);
        tests_run++;
        if (bus.cg_valid !== 1'b0 || bus.cg_count !== 5'd0) begin
            tests_failed++;
            $display("FAIL flush_beat: valid=%b cnt=%0d required 0/0", bus.cg_valid, bus.cg_count);
        end
        clear_cg();
        cg_lvl[0]  = 16'd1;
        cg_last[0] = 1'b1;
        run_cg("after_flush", 0);
    endtask

    task automatic test_async_reset();
        send_beat(16'd0, 1'b0, 16'd10, 16'd5);
        #2 rst_n = 1'b0;
        #10 rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.cg_valid !== 1'b0 || bus.cg_count !== 5'd0) begin
            tests_failed++;
            $display("FAIL async_reset: rdy=%b valid=%b cnt=%0d required 1/0/0",
                     bus.in_ready, bus.cg_valid, bus.cg_count);
        end
        clear_cg();
        cg_lvl[0]  = 16'd2;
        cg_last[0] = 1'b1;
        run_cg("after_reset", 0);
    endtask

    task automatic test_random();
        int n;
        for (int c = 0; c < 30; c++) begin
            clear_cg();
            n = $urandom_range(1, CG_SIZE);
            for (int i = 0; i < n; i++) begin
                case ($urandom % 4)
                    0:       cg_lvl[i] = 16'd0;
                    1:       cg_lvl[i] = 16'd1;
                    2:       cg_lvl[i] = 16'd2;
                    default: cg_lvl[i] = 16'($urandom_range(3, 65535));
                endcase
                cg_g1[i]   = 16'($urandom);
                cg_ab[i]   = 16'($urandom);
                cg_last[i] = (i == n - 1) && ((n < CG_SIZE) || ($urandom % 2 == 1));
            end
            run_cg("random", $urandom_range(0, 3));
        end
    endtask

`ifdef CGRS_TIMEOUT_EN
    task automatic test_timeout();
        resp_en = 1'b0;
        send_beat(16'd1, 1'b1, 16'd10, 16'd5);
        repeat (TIMEOUT) @(negedge clk);
        tests_run++;
        if (bus.err_timeout !== 1'b0 || bus.cg_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_early: err=%b valid=%b required 0/0", bus.err_timeout, bus.cg_valid);
        end
        @(negedge clk);
        tests_run++;
        if (bus.err_timeout !== 1'b1 || bus.cg_valid !== 1'b1 || bus.cg_bits !== 32'd0 ||
            bus.cg_count !== 5'd1) begin
            tests_failed++;
            $display("FAIL timeout_emit: err=%b valid=%b bits=%h cnt=%0d required 1/1/0/1",
                     bus.err_timeout, bus.cg_valid, bus.cg_bits, bus.cg_count);
        end
        bus.cg_ready = 1'b1;
        @(negedge clk);
        bus.cg_ready = 1'b0;
        resp_en = 1'b1;
        req_rd  = req_log.size();
        tests_run++;
        if (bus.err_timeout !== 1'b1 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_sticky: err=%b rdy=%b required 1/1", bus.err_timeout, bus.in_ready);
        end
    endtask
`else
    task automatic test_wait_forever();
        resp_en = 1'b0;
        send_beat(16'd3, 1'b1, 16'd10, 16'd5);
        repeat (100) @(negedge clk);
        tests_run++;
        if (bus.cg_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.err_timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL wait_forever: valid=%b rdy=%b err=%b required 0/0/0",
                     bus.cg_valid, bus.in_ready, bus.err_timeout);
        end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        resp_en = 1'b1;
        req_rd  = req_log.size();
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.cg_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL wait_recover: rdy=%b valid=%b required 1/0", bus.in_ready, bus.cg_valid);
        end
    endtask
`endif

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_level    = '0;
        bus.in_g1_cost  = '0;
        bus.in_abs_cost = '0;
        bus.in_last     = 1'b0;
        bus.flush       = 1'b0;
        bus.cg_ready    = 1'b0;
        test_reset();
        test_basic();
        test_implicit_last();
        test_saturation();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
`ifdef CGRS_TIMEOUT_EN
        test_timeout();
`else
        test_wait_forever();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
